// File: rtl/id_counter_dco_pkg.sv
// ----------------------------------------------------------------------------
// pll_pkg
//   Shared types for the digital PLL DCO stage.
//   shift_req_e : outstanding phase-correction request (none / advance / retard)
//   decode_req  : turns the loop filter's pulse pair into a single request;
//                 simultaneous or absent pulses mean "no request".
// ----------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_ADV  = 2'd1,
        P_RET  = 2'd2
    } shift_req_e;

    function automatic shift_req_e decode_req(input logic pos, input logic neg);
        shift_req_e req;
        req = P_NONE;
        if (pos && !neg) begin
            req = P_ADV;
        end else if (neg && !pos) begin
            req = P_RET;
        end
        return req;
    endfunction

endpackage

// File: rtl/id_counter_dco_latch.sv
// ----------------------------------------------------------------------------
// shift_request_latch
//   Holds at most one outstanding phase correction for the DCO.
//   Opposite-direction requests cancel; same-direction repeats are ignored.
//   On the apply strobe the held request is consumed and replaced by this
//   cycle's decoded request (never merged with the consumed one).
// Ports
//   clk_i            in  system clock
//   reset_i          in  synchronous active-low reset
//   positiveShift_i  in  advance request pulse
//   negativeShift_i  in  retard request pulse
//   apply_i          in  correction is being applied this cycle
//   pending_o        out currently outstanding request
// ----------------------------------------------------------------------------
module shift_request_latch
    import pll_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       positiveShift_i,
    input  logic       negativeShift_i,
    input  logic       apply_i,
    output shift_req_e pending_o
);

    shift_req_e r_state;
    shift_req_e w_next;
    shift_req_e w_req;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= P_NONE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_req  = decode_req(positiveShift_i, negativeShift_i);
        w_next = r_state;
        if (apply_i) begin
            w_next = w_req;
        end else begin
            case (r_state)
                P_NONE:  w_next = w_req;
                P_ADV:   if (w_req == P_RET) w_next = P_NONE;
                P_RET:   if (w_req == P_ADV) w_next = P_NONE;
                default: w_next = P_NONE;
            endcase
        end
    end

    assign pending_o = r_state;

endmodule

// File: rtl/id_counter_dco.sv
// ----------------------------------------------------------------------------
// id_counter_dco
//   Increment/decrement counter DCO. Divides clk_i by DIV_N and applies the
//   loop filter's advance/retard pulses, at most one per recovered period,
//   by shortening or lengthening the period by one clk_i cycle.
//   Optional macro ID_DCO_STATS_EN adds saturating correction counters;
//   without it both counter ports are tied to zero.
// Ports
//   clk_i            in  system clock (DCO reference)
//   reset_i          in  synchronous active-low reset
//   enable_i         in  1 = phase advances, 0 = phase holds
//   positiveShift_i  in  advance request pulse
//   negativeShift_i  in  retard request pulse
//   recoveredClk_o   out phase MSB (high for DIV_N/2..DIV_N-1)
//   samplePulse_o    out 1-cycle mid-bit strobe, one cycle after phase hits DIV_N/2
//   phase_o          out current phase count
//   shiftApplied_o   out 1-cycle pulse after a correction is applied
//   advanceCount_o   out applied advances (ID_DCO_STATS_EN only)
//   retardCount_o    out applied retards (ID_DCO_STATS_EN only)
// ----------------------------------------------------------------------------
module id_counter_dco
    import pll_pkg::*;
#(
    parameter int DIV_N   = 16,
    parameter int PHASE_W = $clog2(DIV_N),
    parameter int STATS_W = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               positiveShift_i,
    input  logic               negativeShift_i,
    output logic               recoveredClk_o,
    output logic               samplePulse_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               shiftApplied_o,
    output logic [STATS_W-1:0] advanceCount_o,
    output logic [STATS_W-1:0] retardCount_o
);

    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(DIV_N - 1);
    localparam logic [PHASE_W-1:0] PH_HALF = PHASE_W'(DIV_N / 2);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phaseNext;
    logic               r_retHold;
    logic               r_changed;
    logic               r_sample;
    logic               r_applied;
    logic               w_apply;
    logic               w_applyAdv;
    logic               w_applyRet;
    shift_req_e         w_pending;

    shift_request_latch u_latch (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .positiveShift_i (positiveShift_i),
        .negativeShift_i (negativeShift_i),
        .apply_i         (w_apply),
        .pending_o       (w_pending)
    );

    // r_retHold marks the extra DIV_N-1 cycle after a retard; a request
    // captured at the retard's apply point must wait for the next period
    // instead of firing on that repeated last phase.
    assign w_apply    = enable_i && (r_phase == PH_LAST) &&
                        (w_pending != P_NONE) && !r_retHold;
    assign w_applyAdv = w_apply && (w_pending == P_ADV);
    assign w_applyRet = w_apply && (w_pending == P_RET);

    // DIV_N is a power of two, so the natural PHASE_W wrap is the modulo.
    always_comb begin
        w_phaseNext = r_phase;
        if (enable_i) begin
            if (w_applyAdv) begin
                w_phaseNext = r_phase + PHASE_W'(2);
            end else if (!w_applyRet) begin
                w_phaseNext = r_phase + PHASE_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_phase   <= '0;
            r_retHold <= 1'b0;
            r_changed <= 1'b0;
            r_sample  <= 1'b0;
            r_applied <= 1'b0;
        end else begin
            r_phase   <= w_phaseNext;
            r_retHold <= w_applyRet ? 1'b1 : (enable_i ? 1'b0 : r_retHold);
            r_changed <= (w_phaseNext != r_phase);
            // Only a fresh arrival at mid-phase strobes; a frozen phase does not.
            r_sample  <= r_changed && (r_phase == PH_HALF);
            r_applied <= w_apply;
        end
    end

`ifdef ID_DCO_STATS_EN
    logic [STATS_W-1:0] r_advCnt;
    logic [STATS_W-1:0] r_retCnt;

    // Counters step on the same edge that raises shiftApplied_o.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_advCnt <= '0;
            r_retCnt <= '0;
        end else begin
            if (w_applyAdv && (r_advCnt != '1)) begin
                r_advCnt <= r_advCnt + STATS_W'(1);
            end
            if (w_applyRet && (r_retCnt != '1)) begin
                r_retCnt <= r_retCnt + STATS_W'(1);
            end
        end
    end

    assign advanceCount_o = r_advCnt;
    assign retardCount_o  = r_retCnt;
`else
    assign advanceCount_o = '0;
    assign retardCount_o  = '0;
`endif

    assign phase_o        = r_phase;
    assign recoveredClk_o = r_phase[PHASE_W-1];
    assign samplePulse_o  = r_sample;
    assign shiftApplied_o = r_applied;

endmodule
